// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder.
// Holds the FSM encoding, the out-of-range read value and the handshake helper.
package memory_responder_pkg;

  typedef enum logic [1:0] {
    S_RECEIVE = 2'd0,
    S_ACCESS  = 2'd1,
    S_SEND    = 2'd2
  } state_t;

  localparam logic [31:0] OUT_OF_RANGE_DATA = 32'h0000_0000;

  function automatic logic xfer(
    input logic valid,
    input logic ready
  );
    return valid & ready;
  endfunction

endpackage

// File: rtl/memory_responder_ram.sv
// Single-port synchronous RAM, 32-bit words, one-cycle read.
// Kept separate so FPGA builds can drop in a vendor block RAM.
module memory_responder_ram #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// Responder end of the memory request channel: one request in,
// one 32-bit response out, backed by an internal word RAM.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int    ADDR_WIDTH     = 10,
  parameter int    ACCESS_LATENCY = 2,
  parameter string INIT_FILE      = ""
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RECEIVE_ADDR_VALID,
  input  logic [31:0] RECEIVE_ADDR,
  input  logic        RECEIVE_DATA_VALID,
  input  logic [31:0] RECEIVE_DATA,
  output logic        RECEIVE_READY,
  output logic        SEND_VALID,
  output logic [31:0] SEND_DATA,
  input  logic        SEND_READY
);

  localparam int CW =
    (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          pend_q;

  logic          rx_hs;
  logic          tx_hs;
  logic          access;
  logic          in_range;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic          ready_nx;
  logic          valid_nx;
  logic          load;
  logic [31:0]   resp;

  assign rx_hs    = xfer(RECEIVE_ADDR_VALID, RECEIVE_READY);
  assign tx_hs    = xfer(SEND_VALID, SEND_READY);
  assign access   = (state == S_ACCESS) && (cnt == '0);
  assign in_range = (addr_q[31:ADDR_WIDTH] == '0);

  memory_responder_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .CLK  (CLK),
    .we   (ram_we),
    .addr (addr_q[ADDR_WIDTH-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_RECEIVE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == S_RECEIVE): if (rx_hs)      state_nx = S_ACCESS;
      (state == S_ACCESS):  if (cnt == '0)  state_nx = S_SEND;
      (state == S_SEND):    if (tx_hs)      state_nx = S_RECEIVE;
      default:                              state_nx = S_RECEIVE;
    endcase
  end

  // RST gates the write so a reset on the commit edge aborts it
  always_comb begin
    ram_we   = access && wr_q && in_range && !RST;
    ready_nx = (state == S_RECEIVE) && !rx_hs;
    load     = (state == S_SEND) && pend_q;
    resp     = wr_q     ? wdata_q :
               in_range ? ram_rdata : OUT_OF_RANGE_DATA;
    valid_nx = SEND_VALID;
    if (load) begin
      valid_nx = 1'b1;
    end else if (tx_hs) begin
      valid_nx = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RECEIVE_READY <= 1'b0;
      SEND_VALID    <= 1'b0;
      SEND_DATA     <= '0;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      RECEIVE_READY <= ready_nx;
      SEND_VALID    <= valid_nx;
      if (load) begin
        SEND_DATA <= resp;
      end
      if (rx_hs) begin
        addr_q  <= RECEIVE_ADDR;
        wdata_q <= RECEIVE_DATA;
        wr_q    <= RECEIVE_DATA_VALID;
        cnt     <= CW'(ACCESS_LATENCY - 1);
      end else if ((state == S_ACCESS) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      // RAM read data lands one cycle after the access edge
      if (access) begin
        pend_q <= 1'b1;
      end else if (load) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder at latencies 2, 1 and 4.
// A reference memory predicts each response; a monitor checks them.
module tb_memory_responder;

  typedef struct {
    logic [31:0] data;
    int          hs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    logic        rst, rav, rdv, rready, svalid, sready;
    logic [31:0] raddr, rdata, sdata;
    int          cyc = 0;
    int          sready_mode = 0;
    int          last_hs = 0;
    int          prev_hs = 0;
    bit          done = 1'b0;
    exp_t        sb[$];
    exp_t        em;
    logic [31:0] model [logic [31:0]];
    logic [31:0] waddrs[$];
    logic        prev_v = 1'b0;
    logic [31:0] held;

    memory_responder #(
      .ADDR_WIDTH    (10),
      .ACCESS_LATENCY(L),
      .INIT_FILE     ("")
    ) dut (
      .CLK               (clk),
      .RST               (rst),
      .RECEIVE_ADDR_VALID(rav),
      .RECEIVE_ADDR      (raddr),
      .RECEIVE_DATA_VALID(rdv),
      .RECEIVE_DATA      (rdata),
      .RECEIVE_READY     (rready),
      .SEND_VALID        (svalid),
      .SEND_DATA         (sdata),
      .SEND_READY        (sready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
      #1;
      case (sready_mode)
        0:       sready = 1'b1;
        1:       sready = ($urandom_range(0, 3) != 0);
        default: sready = 1'b0;
      endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL lane%0d(L=%0d) %s: got 0x%08h expected 0x%08h",
                 g, L, name, act, exp);
      end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic w, input bit want);
      int   n;
      exp_t e;
      bit   inr;
      raddr = a;
      rdata = d;
      rdv   = w;
      rav   = 1'b1;
      n     = 0;
      while (!rready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!rready) begin
        checks++;
        errors++;
        $display("FAIL lane%0d accept_timeout: got no ready, expected ready", g);
        rav = 1'b0;
        return;
      end
      e.hs = cyc + 1;
      inr  = (a < 32'd1024);
      if (w) begin
        e.data = d;
        if (want && inr) model[a] = d;
      end else begin
        e.data = inr ? model[a] : 32'h0;
      end
      if (want) sb.push_back(e);
      prev_hs = last_hs;
      last_hs = e.hs;
      @(negedge clk);
      rav   = 1'b0;
      raddr = $urandom;
      rdata = $urandom;
      rdv   = 1'($urandom);
    endtask

    task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || svalid) && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0 || svalid) begin
        checks++;
        errors++;
        $display("FAIL lane%0d drain_timeout: got %0d pending, expected 0",
                 g, sb.size());
      end
    endtask

    always @(negedge clk) begin
      if (svalid) begin
        chk("ready_low_while_valid", {31'b0, rready}, 32'h0);
        if (!prev_v) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d unexpected_response: got 0x%08h expected none",
                     g, sdata);
          end else begin
            em = sb.pop_front();
            chk("resp_data", sdata, em.data);
            chk("latency", 32'(cyc - em.hs), 32'(L + 1));
          end
          held = sdata;
        end else begin
          chk("data_stable", sdata, held);
        end
      end
      prev_v = svalid;
    end

    initial begin
      int n;
      logic [31:0] a;
      rst = 1'b1; rav = 1'b0; rdv = 1'b0; raddr = '0; rdata = '0;
      repeat (2) @(negedge clk);
      chk("reset_ready", {31'b0, rready}, 32'h0);
      chk("reset_valid", {31'b0, svalid}, 32'h0);
      chk("reset_data", sdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'b0, rready}, 32'h1);

      issue(32'h10, 32'hDEADBEEF, 1'b1, 1'b1);
      issue(32'h10, 32'h0, 1'b0, 1'b1);
      chk("spacing_wr_rd", 32'(last_hs - prev_hs), 32'(L + 4));
      issue(32'h0, 32'h5555AAAA, 1'b1, 1'b1);
      issue(32'h3, 32'hA, 1'b1, 1'b1);
      issue(32'h3, 32'h0, 1'b0, 1'b1);
      chk("spacing_b2b", 32'(last_hs - prev_hs), 32'(L + 4));

      issue(32'h0001_0000, 32'h0, 1'b0, 1'b1);
      issue(32'h0001_0000, 32'h1234, 1'b1, 1'b1);
      issue(32'h0, 32'h0, 1'b0, 1'b1);
      drain();

      sready_mode = 2;
      repeat (2) @(negedge clk);
      issue(32'h10, 32'h0, 1'b0, 1'b1);
      n = 0;
      while (!svalid && n < 30) begin
        @(negedge clk);
        n++;
      end
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("bp_valid_held", {31'b0, svalid}, 32'h1);
        chk("bp_ready_low", {31'b0, rready}, 32'h0);
      end
      sready_mode = 0;
      drain();

      issue(32'h10, 32'hBAD0BAD0, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready", {31'b0, rready}, 32'h0);
      chk("abort_valid", {31'b0, svalid}, 32'h0);
      chk("abort_data", sdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready_back", {31'b0, rready}, 32'h1);
      issue(32'h10, 32'h0, 1'b0, 1'b1);
      drain();

      sready_mode = 1;
      for (int i = 0; i < 40; i++) begin
        if (waddrs.size() == 0 || $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 7) == 0) begin
            a = $urandom | 32'h400;
          end else begin
            a = 32'($urandom_range(0, 63));
            waddrs.push_back(a);
          end
          issue(a, $urandom, 1'b1, 1'b1);
        end else begin
          if ($urandom_range(0, 5) == 0) a = $urandom | 32'h400;
          else a = waddrs[$urandom_range(0, waddrs.size() - 1)];
          issue(a, $urandom, 1'b0, 1'b1);
        end
      end
      sready_mode = 0;
      drain();
      done = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(lane[0].done && lane[1].done && lane[2].done)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got unfinished lanes, expected all done");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
Responder end of the memory request channel. It accepts one address/data request at a time from the memory_accessor and performs a read (peek) or write (poke) on an internal word-addressed RAM. It returns exactly one 32-bit response word per request. It sits on the memory side of the accessor and stands in for the memory controller and backing memory in simulation and small FPGA builds.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth is 2**ADDR_WIDTH 32-bit words.
ACCESS_LATENCY, 2, cycles spent in S_ACCESS per request; must be >= 1.
INIT_FILE, "", optional $readmemh image; empty means the RAM is not preloaded.

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
RECEIVE_ADDR_VALID  in  1  request valid; held until accepted
RECEIVE_ADDR  in  32  word address
RECEIVE_DATA_VALID  in  1  1 = poke (write), 0 = peek (read); sampled with the address
RECEIVE_DATA  in  32  write data; sampled with the address
RECEIVE_READY  out  1  request accept (registered)
SEND_VALID  out  1  response valid (registered)
SEND_DATA  out  32  response word (registered)
SEND_READY  in  1  consumer accept

Behaviour:
- Reset (RST = 1 at a clock edge):
  - outputs: RECEIVE_READY = 0, SEND_VALID = 0, SEND_DATA = 0
  - STATE = S_RECEIVE; latency counter = 0; latched request fields = 0
  - RAM contents are not cleared.
  - Reset asserted mid-transaction aborts it. An aborted write is committed only if its commit cycle has already passed.
- Handshake: a transfer occurs on a cycle where VALID and READY are both 1 at the clock edge. Both READY and VALID are registered and deassert the cycle after the handshake.
- States:
  - S_RECEIVE:
    - RECEIVE_READY rises one cycle after entry, provided no handshake is in progress.
    - On RECEIVE_ADDR_VALID && RECEIVE_READY: latch addr, is_write = RECEIVE_DATA_VALID, wdata; drop READY; go to S_ACCESS; counter = ACCESS_LATENCY-1.
  - S_ACCESS:
    - Counter decrements each cycle.
    - When it reaches 0, perform the access:
      - read: rdata = RAM[addr[ADDR_WIDTH-1:0]]
      - write: RAM[...] <= wdata, and the response word = wdata (write echo)
    - SEND_DATA is loaded that cycle; go to S_SEND.
  - S_SEND:
    - SEND_VALID is asserted and held, with SEND_DATA stable, until SEND_READY.
    - On handshake: drop VALID; go to S_RECEIVE.
- Range check: the access is in range iff addr[31:ADDR_WIDTH] == 0. When out of range:
  - a read returns 32'h0000_0000
  - a write is dropped and the response still echoes wdata
  - a response is always produced, so the initiator never hangs.
- Latency:
  - Request handshake to SEND_VALID high = ACCESS_LATENCY + 1 cycles.
  - Minimum request-to-request spacing = ACCESS_LATENCY + 4 cycles when SEND_READY is held at 1.
- Exactly one outstanding request. RECEIVE_READY is never high outside S_RECEIVE.
- Back-pressure:
  - SEND_READY low for N cycles stretches S_SEND by N cycles.
  - No new request is accepted meanwhile.
  - SEND_DATA must not change while SEND_VALID = 1.
- Request fields change after acceptance: ignored, because only latched copies are used.
- X/undefined RAM words read as whatever the array holds. The bench preloads or writes before reading.

Decomposition:
- Shared package/include: state encodings S_RECEIVE/S_ACCESS/S_SEND (2-bit), the OUT_OF_RANGE_DATA constant (32'h0), and the reuse of the existing sendAlways/receiveAlways handshake macros.
- One natural sub-module: memory_responder_ram, a single-port synchronous RAM (ADDR_WIDTH, INIT_FILE; we, addr, wdata, rdata with 1-cycle read). It lets FPGA builds swap in a vendor block RAM.

Test Plan:
- Write then read:
  - Poke addr 0x10, data 0xDEADBEEF; response 0xDEADBEEF.
  - Peek 0x10; response 0xDEADBEEF, with SEND_VALID exactly ACCESS_LATENCY+1 cycles after each request handshake.
- Back-pressure:
  - Peek with SEND_READY held low 5 cycles; SEND_VALID stays 1 and SEND_DATA is stable for all 5 cycles.
  - RECEIVE_READY stays 0 until the response handshake.
- Out of range:
  - Peek addr 0x0001_0000 (ADDR_WIDTH = 10) returns 0.
  - Poke 0x0001_0000 with 0x1234 echoes 0x1234, and a subsequent peek of addr 0 is unchanged.
- Back-to-back with SEND_READY = 1:
  - Poke 0x3 with 0xA, then immediately peek 0x3; second response 0xA.
  - Request spacing is exactly ACCESS_LATENCY+4 cycles.
- Reset mid-operation:
  - Assert RST during S_ACCESS of a poke before its commit cycle; all outputs are 0 the next cycle.
  - A later peek of that address returns its old value.
  - RECEIVE_READY returns high 1 cycle after RST deasserts.
- Latency sweep:
  - Repeat the write/read scenario with ACCESS_LATENCY = 1 and 4; measured latency is 2 and 5 cycles.
